dram_cmd_monitor: RTL and testbench



---
 rtl/dram_cmd_pkg.sv | 23 ++
 rtl/dram_pin_decode.sv | 28 ++
 rtl/dram_cmd_monitor.sv | 133 +++++++++++++
 tb/tb_dram_cmd_monitor.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dram_cmd_pkg.sv
// Shared DRAM command-bus definitions: command codes, device state encoding and
// default timing, used by both the memory-side monitor and the controller FSMs.
package dram_cmd_pkg;

  typedef logic [2:0] cmd_t;

  localparam cmd_t CMD_NOP   = 3'd0;
  localparam cmd_t CMD_ACT   = 3'd1;
  localparam cmd_t CMD_RD    = 3'd2;
  localparam cmd_t CMD_WR    = 3'd3;
  localparam cmd_t CMD_PRE   = 3'd4;
  localparam cmd_t CMD_REF   = 3'd5;
  localparam cmd_t CMD_MRS   = 3'd6;
  localparam cmd_t CMD_OTHER = 3'd7;

  localparam logic [1:0] ST_IDLE       = 2'd0;
  localparam logic [1:0] ST_ACTIVE     = 2'd1;
  localparam logic [1:0] ST_REFRESHING = 2'd2;

  localparam int TRFC_DEFAULT      = 10;
  localparam int TREFI_MAX_DEFAULT = 7800;

endpackage

// File: rtl/dram_pin_decode.sv
// Combinational decode of the active-low {CS,RAS,CAS,WE} pins into a command code.
module dram_pin_decode
  import dram_cmd_pkg::*;
(
  input  logic cs,
  input  logic ras,
  input  logic cas,
  input  logic we,
  output cmd_t cmd
);

  always_comb begin
    cmd = CMD_NOP;
    if (!cs) begin
      case ({ras, cas, we})
        3'b111:  cmd = CMD_NOP;
        3'b011:  cmd = CMD_ACT;
        3'b101:  cmd = CMD_RD;
        3'b100:  cmd = CMD_WR;
        3'b010:  cmd = CMD_PRE;
        3'b001:  cmd = CMD_REF;
        3'b000:  cmd = CMD_MRS;
        default: cmd = CMD_OTHER;
      endcase
    end
  end

endmodule

// File: rtl/dram_cmd_monitor.sv
// Memory-side endpoint / protocol checker for the DRAM command bus.
// state      | meaning
// IDLE       | no row open, any command may be issued
// ACTIVE     | a row is open; RD/WR/PRE expected
// REFRESHING | tRFC window running; only NOP/DESELECT legal until counter hits 0
module dram_cmd_monitor
  import dram_cmd_pkg::*;
#(
  parameter int TRFC      = TRFC_DEFAULT,
  parameter int TREFI_MAX = TREFI_MAX_DEFAULT,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             CS,
  input  logic             RAS,
  input  logic             CAS,
  input  logic             WE,
  output logic [2:0]       cmd_code,
  output logic             cmd_strobe,
  output logic             busy,
  output logic             row_open,
  output logic [CNT_W-1:0] ref_count,
  output logic             refresh_overdue,
  output logic             trfc_err,
  output logic             ref_err,
  output logic             seq_err
);

  localparam int TW = $clog2(TRFC);
  localparam int IW = $clog2(TREFI_MAX + 1);
  localparam logic [TW-1:0] TRFC_LOAD = TW'(TRFC - 1);
  localparam logic [IW-1:0] IV_MAX    = IW'(TREFI_MAX);
  localparam logic [IW-1:0] IV_LAST   = IW'(TREFI_MAX - 1);

  cmd_t          cmd;
  logic [1:0]    state_q, state_d;
  logic [TW-1:0] trfc_q, trfc_d;
  logic [IW-1:0] iv_q;
  logic          accept, ref_acc, trfc_e, ref_e, seq_e;

  dram_pin_decode u_decode (
    .cs  (CS),
    .ras (RAS),
    .cas (CAS),
    .we  (WE),
    .cmd (cmd)
  );

  always_comb begin
    state_d = state_q;
    trfc_d  = trfc_q;
    accept  = 1'b0;
    ref_acc = 1'b0;
    trfc_e  = 1'b0;
    ref_e   = 1'b0;
    seq_e   = 1'b0;
    if (state_q == ST_REFRESHING && trfc_q != '0) begin
      trfc_d = trfc_q - TW'(1);
      trfc_e = (cmd != CMD_NOP);
    end else if (state_q == ST_ACTIVE) begin
      case (cmd)
        CMD_NOP: ;
        CMD_PRE: begin
          state_d = ST_IDLE;
          accept  = 1'b1;
        end
        CMD_REF: ref_e = 1'b1;
        CMD_ACT, CMD_MRS: seq_e = 1'b1;
        default: accept = 1'b1;
      endcase
    end else begin
      // Idle, or the refresh window expired this cycle and behaves as idle.
      state_d = ST_IDLE;
      case (cmd)
        CMD_NOP: ;
        CMD_ACT: begin
          state_d = ST_ACTIVE;
          accept  = 1'b1;
        end
        CMD_REF: begin
          state_d = ST_REFRESHING;
          trfc_d  = TRFC_LOAD;
          accept  = 1'b1;
          ref_acc = 1'b1;
        end
        CMD_RD, CMD_WR: seq_e = 1'b1;
        default: accept = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      trfc_q     <= '0;
      cmd_code   <= CMD_NOP;
      cmd_strobe <= 1'b0;
      busy       <= 1'b0;
      row_open   <= 1'b0;
      ref_count  <= '0;
      trfc_err   <= 1'b0;
      ref_err    <= 1'b0;
      seq_err    <= 1'b0;
    end else begin
      state_q    <= state_d;
      trfc_q     <= trfc_d;
      cmd_strobe <= accept;
      busy       <= (state_d == ST_REFRESHING);
      row_open   <= (state_d == ST_ACTIVE);
      trfc_err   <= trfc_e;
      ref_err    <= ref_e && !trfc_e;
      seq_err    <= seq_e && !trfc_e && !ref_e;
      if (accept) cmd_code <= cmd;
      if (ref_acc) ref_count <= ref_count + CNT_W'(1);
    end
  end

  // An accepted REF beats the overdue flag when both land on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      iv_q            <= '0;
      refresh_overdue <= 1'b0;
    end else if (ref_acc) begin
      iv_q            <= '0;
      refresh_overdue <= 1'b0;
    end else if (iv_q != IV_MAX) begin
      iv_q <= iv_q + IW'(1);
      if (iv_q == IV_LAST) refresh_overdue <= 1'b1;
    end
  end

endmodule

// File: tb/tb_dram_cmd_monitor.sv
// Directed bench for dram_cmd_monitor with TRFC=10 and TREFI_MAX=20.
module tb_dram_cmd_monitor;

  localparam int TRFC  = 10;
  localparam int TREFI = 20;
  localparam int CW    = 16;

  localparam logic [3:0] P_NOP = 4'b0111;
  localparam logic [3:0] P_ACT = 4'b0011;
  localparam logic [3:0] P_RD  = 4'b0101;
  localparam logic [3:0] P_WR  = 4'b0100;
  localparam logic [3:0] P_PRE = 4'b0010;
  localparam logic [3:0] P_REF = 4'b0001;
  localparam logic [3:0] P_MRS = 4'b0000;
  localparam logic [3:0] P_OTH = 4'b0110;
  localparam logic [3:0] P_DES = 4'b1000;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          CS = 1'b1, RAS = 1'b1, CAS = 1'b1, WE = 1'b1;
  logic [2:0]    cmd_code;
  logic          cmd_strobe, busy, row_open, refresh_overdue;
  logic [CW-1:0] ref_count;
  logic          trfc_err, ref_err, seq_err;

  int n_chk = 0;
  int n_err = 0;

  dram_cmd_monitor #(.TRFC(TRFC), .TREFI_MAX(TREFI), .CNT_W(CW)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .CS              (CS),
    .RAS             (RAS),
    .CAS             (CAS),
    .WE              (WE),
    .cmd_code        (cmd_code),
    .cmd_strobe      (cmd_strobe),
    .busy            (busy),
    .row_open        (row_open),
    .ref_count       (ref_count),
    .refresh_overdue (refresh_overdue),
    .trfc_err        (trfc_err),
    .ref_err         (ref_err),
    .seq_err         (seq_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic bus(input logic [3:0] p);
    {CS, RAS, CAS, WE} = p;
    @(posedge clk);
    #1;
  endtask

  task automatic nops(input int n);
    for (int i = 0; i < n; i++) bus(P_NOP);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_code"},   32'(cmd_code), 0);
    chk({tag, "_strobe"}, 32'(cmd_strobe), 0);
    chk({tag, "_busy"},   32'(busy), 0);
    chk({tag, "_row"},    32'(row_open), 0);
    chk({tag, "_refcnt"}, 32'(ref_count), 0);
    chk({tag, "_ovd"},    32'(refresh_overdue), 0);
    chk({tag, "_errs"},   32'({trfc_err, ref_err, seq_err}), 0);
  endtask

  // Reset is released on a falling edge, so the next rising edge is edge 1.
  task automatic do_reset(input string tag);
    {CS, RAS, CAS, WE} = P_NOP;
    rst_n = 1'b0;
    #3;
    check_zero(tag);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // Basic REF window, deselect handling
    do_reset("rst0");
    bus(P_DES);
    chk("des_strobe", 32'(cmd_strobe), 0);
    chk("des_code",   32'(cmd_code), 0);
    nops(3);
    bus(P_REF);
    chk("t1_busy_5",   32'(busy), 1);
    chk("t1_refcnt",   32'(ref_count), 1);
    chk("t1_code",     32'(cmd_code), 5);
    chk("t1_strobe",   32'(cmd_strobe), 1);
    bus(P_NOP);
    chk("t1_strobe_6", 32'(cmd_strobe), 0);
    chk("t1_busy_6",   32'(busy), 1);
    for (int e = 7; e <= 14; e++) begin
      bus(P_NOP);
      chk($sformatf("t1_busy_%0d", e), 32'(busy), 1);
    end
    bus(P_NOP);
    chk("t1_busy_15", 32'(busy), 0);

    // Command inside tRFC window, then accepted at edge 15
    do_reset("rst1");
    nops(4);
    bus(P_REF);
    nops(3);
    bus(P_ACT);
    chk("t2_trfc_err", 32'(trfc_err), 1);
    chk("t2_row",      32'(row_open), 0);
    chk("t2_code",     32'(cmd_code), 5);
    chk("t2_strobe",   32'(cmd_strobe), 0);
    chk("t2_busy",     32'(busy), 1);
    bus(P_NOP);
    chk("t2_trfc_err_clr", 32'(trfc_err), 0);
    nops(4);
    bus(P_ACT);
    chk("t2_row_15",  32'(row_open), 1);
    chk("t2_code_15", 32'(cmd_code), 1);
    chk("t2_busy_15", 32'(busy), 0);
    chk("t2_err_15",  32'({trfc_err, ref_err, seq_err}), 0);

    // Row-open behaviour and sequence errors
    bus(P_RD);
    chk("t3_rd_code", 32'(cmd_code), 2);
    chk("t3_rd_stb",  32'(cmd_strobe), 1);
    bus(P_MRS);
    chk("t3_mrs_seq",  32'(seq_err), 1);
    chk("t3_mrs_code", 32'(cmd_code), 2);
    chk("t3_mrs_stb",  32'(cmd_strobe), 0);
    chk("t3_mrs_row",  32'(row_open), 1);
    bus(P_REF);
    chk("t3_ref_err",    32'(ref_err), 1);
    chk("t3_ref_seq",    32'(seq_err), 0);
    chk("t3_ref_cnt",    32'(ref_count), 1);
    chk("t3_ref_row",    32'(row_open), 1);
    chk("t3_ref_busy",   32'(busy), 0);
    bus(P_PRE);
    chk("t3_pre_row",  32'(row_open), 0);
    chk("t3_pre_code", 32'(cmd_code), 4);
    chk("t3_pre_rerr", 32'(ref_err), 0);
    bus(P_REF);
    chk("t3_ref2_cnt",  32'(ref_count), 2);
    chk("t3_ref2_busy", 32'(busy), 1);
    chk("t3_ref2_code", 32'(cmd_code), 5);
    nops(9);
    chk("t3_busy_last", 32'(busy), 1);
    bus(P_RD);
    chk("t3_idle_rd_seq",  32'(seq_err), 1);
    chk("t3_idle_rd_busy", 32'(busy), 0);
    chk("t3_idle_rd_code", 32'(cmd_code), 5);
    bus(P_MRS);
    chk("t3_idle_mrs", 32'(cmd_code), 6);
    chk("t3_mrs_stb2", 32'(cmd_strobe), 1);
    bus(P_OTH);
    chk("t3_other", 32'(cmd_code), 7);
    bus(P_DES);
    chk("t3_des_stb",  32'(cmd_strobe), 0);
    chk("t3_des_code", 32'(cmd_code), 7);
    bus(P_WR);
    chk("t3_idle_wr_seq", 32'(seq_err), 1);

    // Refresh interval / overdue flag
    do_reset("rst2");
    nops(19);
    chk("t4_ovd_19", 32'(refresh_overdue), 0);
    bus(P_NOP);
    chk("t4_ovd_20", 32'(refresh_overdue), 1);
    bus(P_NOP);
    chk("t4_ovd_21", 32'(refresh_overdue), 1);
    bus(P_REF);
    chk("t4_ovd_clr",  32'(refresh_overdue), 0);
    chk("t4_cnt_clr",  32'(ref_count), 1);
    nops(19);
    chk("t4_ovd_41", 32'(refresh_overdue), 0);
    bus(P_REF);
    chk("t4_ovd_race", 32'(refresh_overdue), 0);
    chk("t4_cnt_race", 32'(ref_count), 2);
    bus(P_NOP);
    chk("t4_ovd_after", 32'(refresh_overdue), 0);

    // Back-to-back REF
    do_reset("rst3");
    nops(4);
    bus(P_REF);
    for (int e = 6; e <= 14; e++) begin
      bus(P_NOP);
      chk($sformatf("t5_busy_%0d", e), 32'(busy), 1);
    end
    bus(P_REF);
    chk("t5_busy_15", 32'(busy), 1);
    chk("t5_cnt",     32'(ref_count), 2);
    chk("t5_strobe",  32'(cmd_strobe), 1);
    chk("t5_terr",    32'(trfc_err), 0);
    nops(9);
    chk("t5_busy_24", 32'(busy), 1);
    bus(P_NOP);
    chk("t5_busy_25", 32'(busy), 0);

    // Reset in the middle of a tRFC window
    do_reset("rst4");
    nops(4);
    bus(P_REF);
    nops(2);
    rst_n = 1'b0;
    #1;
    check_zero("t6_mid");
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    bus(P_REF);
    chk("t6_ref_cnt",  32'(ref_count), 1);
    chk("t6_ref_busy", 32'(busy), 1);
    chk("t6_ref_code", 32'(cmd_code), 5);
    chk("t6_ref_terr", 32'(trfc_err), 0);

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule
